spine_switch: RTL and testbench

- Group-level spine switch, directly downstream of each tile's router spine outputs (spineX1_out_data/valid).
- Collects one spine output from each of NPORTS tiles and buffers each in a per-input FIFO.
- Routes each flit by its destination field, data[15:10], to the matching tile's spine input (in_data/in_valid/dest_addr).
- Spine links have no ready signal, so overflow is dropped and counted, never back-pressured.

---
 rtl/spine_pkg.sv | 22 ++
 rtl/spine_in_fifo.sv | 60 ++++++
 rtl/spine_switch.sv | 150 +++++++++++++++
 tb/tb_spine_switch.sv | 293 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/spine_pkg.sv
`default_nettype none
// ============================================================================
// Module   : spine_pkg
// Purpose  : Shared widths and the destination-field helper for the spine
//            switch slice.
// Revision : 1.0 - initial release
// ============================================================================
package spine_pkg;

    localparam int DEST_W     = 6;
    localparam int PORT_SEL_W = 2;
    localparam int DROP_CNT_W = 8;
    localparam int MAX_FLIT_W = 64;

    // Flits narrower than MAX_FLIT_W are zero-extended by the caller.
    function automatic logic [DEST_W-1:0] dest_of(input logic [MAX_FLIT_W-1:0] flit,
                                                  input int unsigned           dwidth);
        return DEST_W'(flit >> (dwidth - DEST_W));
    endfunction

endpackage
`default_nettype wire

// File: rtl/spine_in_fifo.sv
`default_nettype none
// ============================================================================
// Module   : spine_in_fifo
// Purpose  : Per-input synchronous FIFO; a push while full is ignored even if
//            a pop happens on the same edge.
// Revision : 1.0 - initial release
// ============================================================================
module spine_in_fifo #(
    parameter int DWIDTH = 16,
    parameter int DEPTH  = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              i_push,
    input  logic [DWIDTH-1:0] i_data,
    input  logic              i_pop,
    output logic [DWIDTH-1:0] o_head,
    output logic              o_full,
    output logic              o_empty
);

    localparam int c_PTR_W = $clog2(DEPTH);

    logic [DWIDTH-1:0]  r_mem [DEPTH];
    logic [c_PTR_W-1:0] r_wr_ptr;
    logic [c_PTR_W-1:0] r_rd_ptr;
    logic [c_PTR_W:0]   r_count;
    logic               w_push_ok;
    logic               w_pop_ok;

    assign o_full    = (r_count == (c_PTR_W+1)'(DEPTH));
    assign o_empty   = (r_count == '0);
    assign o_head    = r_mem[r_rd_ptr];
    assign w_push_ok = i_push && !o_full;
    assign w_pop_ok  = i_pop && !o_empty;

    always_ff @(posedge clk) begin
        if (w_push_ok) begin
            r_mem[r_wr_ptr] <= i_data;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push_ok) begin
                r_wr_ptr <= r_wr_ptr + c_PTR_W'(1);
            end
            if (w_pop_ok) begin
                r_rd_ptr <= r_rd_ptr + c_PTR_W'(1);
            end
            r_count <= r_count + (c_PTR_W+1)'(w_push_ok) - (c_PTR_W+1)'(w_pop_ok);
        end
    end

endmodule
`default_nettype wire

// File: rtl/spine_switch.sv
`default_nettype none
// ============================================================================
// Module   : spine_switch
// Purpose  : Group-level spine switch: per-input FIFOs, destination decode and
//            one round-robin arbiter plus output register per tile port.
// Revision : 1.0 - initial release
// ============================================================================
module spine_switch
    import spine_pkg::*;
#(
    parameter int NPORTS     = 4,
    parameter int DWIDTH     = 16,
    parameter int FIFO_DEPTH = 4,
    parameter int SEL_LSB    = 0
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic [NPORTS*DWIDTH-1:0]     in_data,
    input  logic [NPORTS-1:0]            in_valid,
    output logic [NPORTS*DWIDTH-1:0]     out_data,
    output logic [NPORTS-1:0]            out_valid,
    output logic [NPORTS*DEST_W-1:0]     out_dest,
    output logic [NPORTS-1:0]            fifo_full,
    output logic [NPORTS-1:0]            fifo_empty,
    output logic [NPORTS-1:0]            drop_pulse,
    output logic [NPORTS*DROP_CNT_W-1:0] drop_count,
    output logic                         busy
);

    logic [NPORTS-1:0][DWIDTH-1:0]     w_head;
    logic [NPORTS-1:0][DEST_W-1:0]     w_dest;
    logic [NPORTS-1:0][PORT_SEL_W-1:0] w_tgt;
    logic [NPORTS-1:0]                 w_full;
    logic [NPORTS-1:0]                 w_empty;
    logic [NPORTS-1:0]                 w_pop;
    logic [NPORTS-1:0]                 w_gnt_vld;
    logic [NPORTS-1:0][PORT_SEL_W-1:0] w_gnt_idx;

    assign fifo_full  = w_full;
    assign fifo_empty = w_empty;
    assign busy       = (|(~w_empty)) | (|out_valid);

    generate
        for (genvar i = 0; i < NPORTS; i++) begin : g_in
            logic                  r_drop_pulse;
            logic [DROP_CNT_W-1:0] r_drop_cnt;
            logic                  w_drop;

            spine_in_fifo #(
                .DWIDTH (DWIDTH),
                .DEPTH  (FIFO_DEPTH)
            ) u_fifo (
                .clk     (clk),
                .reset   (reset),
                .i_push  (in_valid[i]),
                .i_data  (in_data[i*DWIDTH +: DWIDTH]),
                .i_pop   (w_pop[i]),
                .o_head  (w_head[i]),
                .o_full  (w_full[i]),
                .o_empty (w_empty[i])
            );

            assign w_dest[i] = dest_of(MAX_FLIT_W'(w_head[i]), DWIDTH);
            assign w_tgt[i]  = w_dest[i][SEL_LSB +: PORT_SEL_W];

            // Full is the registered pre-pop state, so a same-edge pop never rescues a push.
            assign w_drop = in_valid[i] && w_full[i];

            always_ff @(posedge clk) begin
                if (reset) begin
                    r_drop_pulse <= 1'b0;
                    r_drop_cnt   <= '0;
                end else begin
                    r_drop_pulse <= w_drop;
                    if (w_drop && (r_drop_cnt != '1)) begin
                        r_drop_cnt <= r_drop_cnt + DROP_CNT_W'(1);
                    end
                end
            end

            assign drop_pulse[i]                           = r_drop_pulse;
            assign drop_count[i*DROP_CNT_W +: DROP_CNT_W]  = r_drop_cnt;
        end

        for (genvar o = 0; o < NPORTS; o++) begin : g_out
            logic [NPORTS-1:0]     w_req;
            logic                  w_vld;
            logic [PORT_SEL_W-1:0] w_idx;
            logic [PORT_SEL_W-1:0] r_rr;
            logic [DWIDTH-1:0]     r_data;
            logic [DEST_W-1:0]     r_dest;
            logic                  r_valid;

            always_comb begin
                w_req = '0;
                for (int i = 0; i < NPORTS; i++) begin
                    w_req[i] = !w_empty[i] && (w_tgt[i] == PORT_SEL_W'(o));
                end
            end

            // First requester at or after r_rr, wrapping through the 2-bit index.
            always_comb begin
                w_vld = 1'b0;
                w_idx = '0;
                for (int k = 0; k < NPORTS; k++) begin
                    if (!w_vld && w_req[r_rr + PORT_SEL_W'(k)]) begin
                        w_vld = 1'b1;
                        w_idx = r_rr + PORT_SEL_W'(k);
                    end
                end
            end

            always_ff @(posedge clk) begin
                if (reset) begin
                    r_rr    <= '0;
                    r_data  <= '0;
                    r_dest  <= '0;
                    r_valid <= 1'b0;
                end else begin
                    r_valid <= w_vld;
                    if (w_vld) begin
                        r_data <= w_head[w_idx];
                        r_dest <= w_dest[w_idx];
                        r_rr   <= w_idx + PORT_SEL_W'(1);
                    end
                end
            end

            assign w_gnt_vld[o]                     = w_vld;
            assign w_gnt_idx[o]                     = w_idx;
            assign out_valid[o]                     = r_valid;
            assign out_data[o*DWIDTH +: DWIDTH]     = r_data;
            assign out_dest[o*DEST_W +: DEST_W]     = r_dest;
        end
    endgenerate

    // Each head targets one output, so at most one arbiter can select a given input.
    always_comb begin
        w_pop = '0;
        for (int o = 0; o < NPORTS; o++) begin
            for (int i = 0; i < NPORTS; i++) begin
                if (w_gnt_vld[o] && (w_gnt_idx[o] == PORT_SEL_W'(i))) begin
                    w_pop[i] = 1'b1;
                end
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_spine_switch.sv
`default_nettype none
// ============================================================================
// Module   : tb_spine_switch
// Purpose  : Self-checking bench for spine_switch with a queue-based model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_spine_switch;

    localparam int NP    = 4;
    localparam int DW    = 16;
    localparam int DEPTH = 4;
    localparam int SEL   = 0;

    logic               clk = 1'b0;
    logic               reset;
    logic [NP*DW-1:0]   in_data;
    logic [NP-1:0]      in_valid;
    logic [NP*DW-1:0]   out_data;
    logic [NP-1:0]      out_valid;
    logic [NP*6-1:0]    out_dest;
    logic [NP-1:0]      fifo_full;
    logic [NP-1:0]      fifo_empty;
    logic [NP-1:0]      drop_pulse;
    logic [NP*8-1:0]    drop_count;
    logic               busy;

    int checks = 0;
    int errors = 0;

    logic [DW-1:0] mq [NP][$];
    int            m_rr  [NP];
    int            m_cnt [NP];
    logic [DW-1:0] m_data[NP];
    logic [NP-1:0] m_valid;
    logic [NP-1:0] m_drop;

    always #5 clk = ~clk;

    spine_switch #(
        .NPORTS     (NP),
        .DWIDTH     (DW),
        .FIFO_DEPTH (DEPTH),
        .SEL_LSB    (SEL)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .in_data    (in_data),
        .in_valid   (in_valid),
        .out_data   (out_data),
        .out_valid  (out_valid),
        .out_dest   (out_dest),
        .fifo_full  (fifo_full),
        .fifo_empty (fifo_empty),
        .drop_pulse (drop_pulse),
        .drop_count (drop_count),
        .busy       (busy)
    );

    function automatic int tgt_of(input logic [DW-1:0] f);
        return int'((f >> (DW - 6 + SEL)) & 16'd3);
    endfunction

    // Drive one cycle of inputs, advance one edge, update the model from its rules.
    task automatic step(input logic r, input logic [NP-1:0] v, input logic [NP*DW-1:0] d);
        int            gnt [NP];
        bit            acc [NP];
        logic [DW-1:0] f;
        reset    = r;
        in_valid = v;
        in_data  = d;
        @(posedge clk);
        if (r) begin
            for (int i = 0; i < NP; i++) begin
                mq[i].delete();
                m_rr[i]   = 0;
                m_cnt[i]  = 0;
                m_data[i] = '0;
            end
            m_valid = '0;
            m_drop  = '0;
        end else begin
            for (int o = 0; o < NP; o++) begin
                gnt[o] = -1;
                for (int k = 0; k < NP; k++) begin
                    int i;
                    i = (m_rr[o] + k) % NP;
                    if (gnt[o] < 0 && mq[i].size() > 0) begin
                        f = mq[i][0];
                        if (tgt_of(f) == o) gnt[o] = i;
                    end
                end
            end
            for (int i = 0; i < NP; i++) begin
                acc[i]    = v[i] && (mq[i].size() < DEPTH);
                m_drop[i] = v[i] && (mq[i].size() == DEPTH);
                if (m_drop[i] && m_cnt[i] < 255) m_cnt[i]++;
            end
            for (int o = 0; o < NP; o++) begin
                m_valid[o] = (gnt[o] >= 0);
                if (gnt[o] >= 0) begin
                    m_data[o] = mq[gnt[o]].pop_front();
                    m_rr[o]   = (gnt[o] + 1) % NP;
                end
            end
            for (int i = 0; i < NP; i++) begin
                if (acc[i]) mq[i].push_back(d[i*DW +: DW]);
            end
        end
        #1;
    endtask

    task automatic test_reset();
        step(1'b1, '0, '0);
        step(1'b1, '0, '0);
        checks++; if (out_valid !== 4'h0)    begin errors++; $display("FAIL reset_out_valid got %h want 0", out_valid); end
        checks++; if (fifo_empty !== 4'hF)   begin errors++; $display("FAIL reset_fifo_empty got %h want F", fifo_empty); end
        checks++; if (fifo_full !== 4'h0)    begin errors++; $display("FAIL reset_fifo_full got %h want 0", fifo_full); end
        checks++; if (drop_count !== '0)     begin errors++; $display("FAIL reset_drop_count got %h want 0", drop_count); end
        checks++; if (drop_pulse !== 4'h0)   begin errors++; $display("FAIL reset_drop_pulse got %h want 0", drop_pulse); end
        checks++; if (out_data !== '0)       begin errors++; $display("FAIL reset_out_data got %h want 0", out_data); end
        checks++; if (out_dest !== '0)       begin errors++; $display("FAIL reset_out_dest got %h want 0", out_dest); end
        checks++; if (busy !== 1'b0)         begin errors++; $display("FAIL reset_busy got %b want 0", busy); end
    endtask

    task automatic test_single_flit();
        step(1'b1, '0, '0);
        for (int c = 0; c < 3; c++) step(1'b0, '0, '0);
        step(1'b0, 4'b0001, {48'h0, 16'h0C12});
        checks++; if (out_valid !== 4'h0)     begin errors++; $display("FAIL single_early_valid got %h want 0", out_valid); end
        checks++; if (fifo_empty !== 4'hE)    begin errors++; $display("FAIL single_fifo_empty got %h want E", fifo_empty); end
        checks++; if (busy !== 1'b1)          begin errors++; $display("FAIL single_busy got %b want 1", busy); end
        step(1'b0, '0, '0);
        checks++; if (out_valid !== 4'b1000)  begin errors++; $display("FAIL single_valid got %h want 8", out_valid); end
        checks++; if (out_data[3*DW +: DW] !== 16'h0C12) begin errors++; $display("FAIL single_data got %h want 0c12", out_data[3*DW +: DW]); end
        checks++; if (out_dest[3*6 +: 6] !== 6'h03) begin errors++; $display("FAIL single_dest got %h want 03", out_dest[3*6 +: 6]); end
        step(1'b0, '0, '0);
        checks++; if (out_valid !== 4'h0)     begin errors++; $display("FAIL single_pulse got %h want 0", out_valid); end
        checks++; if (out_data[3*DW +: DW] !== 16'h0C12) begin errors++; $display("FAIL single_hold got %h want 0c12", out_data[3*DW +: DW]); end
    endtask

    task automatic test_contention();
        logic [DW-1:0] exp_seq [5];
        exp_seq = '{16'h0801, 16'h0802, 16'h0803, 16'h0804, 16'h0805};
        step(1'b1, '0, '0);
        step(1'b0, 4'b0111, {16'h0000, 16'h0803, 16'h0802, 16'h0801});
        for (int c = 0; c < 3; c++) begin
            step(1'b0, '0, '0);
            checks++; if (out_valid !== 4'b0100 || out_data[2*DW +: DW] !== exp_seq[c]) begin
                errors++; $display("FAIL contention_%0d got v=%h d=%h want v=4 d=%h", c, out_valid, out_data[2*DW +: DW], exp_seq[c]);
            end
        end
        // Pointer now sits at 3, so port 3 must beat port 0.
        step(1'b0, 4'b1001, {16'h0804, 16'h0000, 16'h0000, 16'h0805});
        for (int c = 3; c < 5; c++) begin
            step(1'b0, '0, '0);
            checks++; if (out_valid !== 4'b0100 || out_data[2*DW +: DW] !== exp_seq[c]) begin
                errors++; $display("FAIL contention_rr_%0d got v=%h d=%h want v=4 d=%h", c, out_valid, out_data[2*DW +: DW], exp_seq[c]);
            end
        end
    endtask

    task automatic test_parallel();
        step(1'b1, '0, '0);
        step(1'b0, 4'hF, {16'h0044, 16'h0C33, 16'h0822, 16'h0411});
        checks++; if (out_valid !== 4'h0) begin errors++; $display("FAIL parallel_early got %h want 0", out_valid); end
        step(1'b0, '0, '0);
        checks++; if (out_valid !== 4'hF) begin errors++; $display("FAIL parallel_valid got %h want F", out_valid); end
        checks++; if (out_data !== {16'h0C33, 16'h0822, 16'h0411, 16'h0044}) begin
            errors++; $display("FAIL parallel_data got %h want 0c33082204110044", out_data);
        end
        checks++; if (out_dest !== {6'h03, 6'h02, 6'h01, 6'h00}) begin
            errors++; $display("FAIL parallel_dest got %h want %h", out_dest, {6'h03, 6'h02, 6'h01, 6'h00});
        end
    endtask

    task automatic test_overflow();
        logic [DW-1:0] sent_ok [$];
        logic [DW-1:0] seen    [$];
        logic [NP*DW-1:0] d;
        bit saw_full;
        int pulses;
        saw_full = 0;
        pulses   = 0;
        step(1'b1, '0, '0);
        for (int c = 0; c < 6; c++) begin
            for (int i = 0; i < NP; i++) d[i*DW +: DW] = {6'd0, 2'(i), 8'(c)};
            step(1'b0, 4'hF, d);
            if (!m_drop[1]) sent_ok.push_back(d[DW +: DW]);
            if (fifo_full[1]) saw_full = 1;
            if (out_valid[0] && out_data[9:8] == 2'd1) seen.push_back(out_data[DW-1:0]);
            checks++; if (drop_pulse !== m_drop) begin errors++; $display("FAIL overflow_pulse c%0d got %h want %h", c, drop_pulse, m_drop); end
        end
        for (int c = 0; c < 24; c++) begin
            step(1'b0, '0, '0);
            if (drop_pulse[1]) pulses++;
            if (out_valid[0] && out_data[9:8] == 2'd1) seen.push_back(out_data[DW-1:0]);
        end
        checks++; if (!saw_full) begin errors++; $display("FAIL overflow_full got 0 want 1"); end
        checks++; if (drop_count[8 +: 8] !== 8'(m_cnt[1])) begin errors++; $display("FAIL overflow_count got %0d want %0d", drop_count[8 +: 8], m_cnt[1]); end
        checks++; if (drop_count[8 +: 8] === 8'd0) begin errors++; $display("FAIL overflow_nodrop got 0 want >0"); end
        checks++; if (seen.size() != sent_ok.size()) begin errors++; $display("FAIL overflow_survivors got %0d want %0d", seen.size(), sent_ok.size()); end
        for (int k = 0; k < sent_ok.size() && k < seen.size(); k++) begin
            checks++; if (seen[k] !== sent_ok[k]) begin errors++; $display("FAIL overflow_order %0d got %h want %h", k, seen[k], sent_ok[k]); end
        end
        checks++; if (pulses != 0) begin errors++; $display("FAIL overflow_late_pulse got %0d want 0", pulses); end
    endtask

    task automatic test_saturation();
        logic [7:0] prev;
        prev = '0;
        step(1'b1, '0, '0);
        for (int c = 0; c < 500; c++) begin
            step(1'b0, 4'hF, {16'h0003, 16'h0002, 16'h0001, 16'h0000});
            if (drop_count[16 +: 8] < prev) begin
                checks++; errors++; $display("FAIL saturation_wrap c%0d got %0d prev %0d", c, drop_count[16 +: 8], prev);
            end
            prev = drop_count[16 +: 8];
        end
        checks++; if (drop_count[16 +: 8] !== 8'd255) begin errors++; $display("FAIL saturation_count got %0d want 255", drop_count[16 +: 8]); end
        checks++; if (drop_count !== {8'(m_cnt[3]), 8'(m_cnt[2]), 8'(m_cnt[1]), 8'(m_cnt[0])}) begin
            errors++; $display("FAIL saturation_all got %h", drop_count);
        end
    endtask

    task automatic test_reset_mid();
        for (int c = 0; c < 20; c++) step(1'b0, '0, '0);
        step(1'b0, 4'b0111, {16'h0000, 16'h0403, 16'h0402, 16'h0401});
        step(1'b1, '0, '0);
        checks++; if (out_valid !== 4'h0)  begin errors++; $display("FAIL midreset_valid got %h want 0", out_valid); end
        checks++; if (fifo_empty !== 4'hF) begin errors++; $display("FAIL midreset_empty got %h want F", fifo_empty); end
        checks++; if (drop_count !== '0)   begin errors++; $display("FAIL midreset_count got %h want 0", drop_count); end
        for (int c = 0; c < 10; c++) begin
            step(1'b0, '0, '0);
            checks++; if (out_valid !== 4'h0 || busy !== 1'b0) begin
                errors++; $display("FAIL midreset_ghost c%0d got v=%h busy=%b want 0", c, out_valid, busy);
            end
        end
    endtask

    task automatic test_random();
        logic [NP-1:0]    v;
        logic [NP*DW-1:0] d;
        logic [NP-1:0]    e_empty, e_full;
        step(1'b1, '0, '0);
        for (int c = 0; c < 400; c++) begin
            v = 4'($urandom_range(0, 15));
            d = {$urandom, $urandom};
            step(1'b0, v, d);
            for (int i = 0; i < NP; i++) begin
                e_empty[i] = (mq[i].size() == 0);
                e_full[i]  = (mq[i].size() == DEPTH);
            end
            checks++; if (out_valid !== m_valid) begin errors++; $display("FAIL rand_valid c%0d got %h want %h", c, out_valid, m_valid); end
            checks++; if (drop_pulse !== m_drop) begin errors++; $display("FAIL rand_drop c%0d got %h want %h", c, drop_pulse, m_drop); end
            checks++; if (fifo_empty !== e_empty || fifo_full !== e_full) begin
                errors++; $display("FAIL rand_status c%0d got e=%h f=%h want e=%h f=%h", c, fifo_empty, fifo_full, e_empty, e_full);
            end
            checks++; if (busy !== ((|(~e_empty)) | (|m_valid))) begin errors++; $display("FAIL rand_busy c%0d got %b", c, busy); end
            for (int o = 0; o < NP; o++) begin
                checks++; if (out_data[o*DW +: DW] !== m_data[o] || out_dest[o*6 +: 6] !== m_data[o][DW-1 -: 6]) begin
                    errors++; $display("FAIL rand_data c%0d o%0d got %h/%h want %h", c, o, out_data[o*DW +: DW], out_dest[o*6 +: 6], m_data[o]);
                end
                checks++; if (drop_count[o*8 +: 8] !== 8'(m_cnt[o])) begin
                    errors++; $display("FAIL rand_count c%0d o%0d got %0d want %0d", c, o, drop_count[o*8 +: 8], m_cnt[o]);
                end
            end
        end
    endtask

    initial begin
        reset    = 1'b1;
        in_valid = '0;
        in_data  = '0;
        test_reset();
        test_single_flit();
        test_contention();
        test_parallel();
        test_overflow();
        test_saturation();
        test_reset_mid();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog got timeout want completion");
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire
